// File: rtl/ram_loader.sv
// Program loader: takes bytes off a valid/ready stream and writes them into RAM
// through the shared bus and the MAR, holding the CPU in clear while it works.
module ram_loader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  i_CLOCK,
    input  logic                  i_CLEAR_n,
    input  logic                  i_START,
    input  logic [ADDR_WIDTH:0]   i_LENGTH,
    input  logic                  i_ABORT,
    input  logic                  i_WR_VALID,
    input  logic [DATA_WIDTH-1:0] i_WR_DATA,
    output logic                  o_WR_READY,
    output logic [DATA_WIDTH-1:0] o_BUS_DATA,
    output logic                  o_BUS_OE,
    output logic                  o_MAR_IN,
    output logic                  o_RAM_IN,
    output logic                  o_CPU_CLEAR_n,
    output logic                  o_BUSY,
    output logic                  o_DONE,
    output logic                  o_ERROR
);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_SET, S_WRITE, S_DONE} state_t;

    localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [ADDR_WIDTH:0]     cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [ADDR_WIDTH:0]     len_clamp;

    logic                    ready_q, ready_d;
    logic [DATA_WIDTH-1:0]   bus_data_q, bus_data_d;
    logic                    oe_q, oe_d;
    logic                    mar_q, mar_d;
    logic                    ram_q, ram_d;
    logic                    cpu_clr_n_q, cpu_clr_n_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;

    assign len_clamp = (i_LENGTH > DEPTH) ? DEPTH : i_LENGTH;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (i_START) begin
                    cnt_d   = len_clamp;
                    addr_d  = '0;
                    err_d   = 1'b0;
                    state_d = (len_clamp == '0) ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                // Abort beats a simultaneous valid byte, which stays unconsumed.
                if (i_ABORT) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else if (i_WR_VALID && ready_q) begin
                    data_d  = i_WR_DATA;
                    state_d = S_SET;
                end
            end
            S_SET: begin
                if (i_ABORT) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (i_ABORT) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == {{ADDR_WIDTH{1'b0}}, 1'b1}) begin
                        state_d = S_DONE;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = S_WAIT;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are decoded from the next state so they register in step with it.
        ready_d    = (state_d == S_WAIT);
        mar_d      = (state_d == S_SET);
        ram_d      = (state_d == S_WRITE);
        oe_d       = mar_d || ram_d;
        busy_d     = ready_d || oe_d;
        done_d     = (state_d == S_DONE);
        bus_data_d = mar_d ? DATA_WIDTH'(addr_d) : (ram_d ? data_d : '0);
        // After an abort the CPU stays held until a load actually completes.
        cpu_clr_n_d = busy_d ? 1'b0 : (done_d ? 1'b1 : cpu_clr_n_q);
    end

    always_ff @(posedge i_CLOCK or negedge i_CLEAR_n) begin
        if (!i_CLEAR_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            cnt_q       <= '0;
            data_q      <= '0;
            ready_q     <= 1'b0;
            bus_data_q  <= '0;
            oe_q        <= 1'b0;
            mar_q       <= 1'b0;
            ram_q       <= 1'b0;
            cpu_clr_n_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            ready_q     <= ready_d;
            bus_data_q  <= bus_data_d;
            oe_q        <= oe_d;
            mar_q       <= mar_d;
            ram_q       <= ram_d;
            cpu_clr_n_q <= cpu_clr_n_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign o_WR_READY    = ready_q;
    assign o_BUS_DATA    = bus_data_q;
    assign o_BUS_OE      = oe_q;
    assign o_MAR_IN      = mar_q;
    assign o_RAM_IN      = ram_q;
    assign o_CPU_CLEAR_n = cpu_clr_n_q;
    assign o_BUSY        = busy_q;
    assign o_DONE        = done_q;
    assign o_ERROR       = err_q;

endmodule

// File: tb/tb_ram_loader.sv
// Directed bench for ram_loader: expected RAM writes queued as bytes are offered,
// then matched against MAR/RAM strobes seen on the bus.
module tb_ram_loader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_START = 1'b0;
    logic [4:0] i_LENGTH = '0;
    logic       i_ABORT = 1'b0;
    logic       i_WR_VALID = 1'b0;
    logic [7:0] i_WR_DATA = '0;
    logic       o_WR_READY, o_BUS_OE, o_MAR_IN, o_RAM_IN;
    logic       o_CPU_CLEAR_n, o_BUSY, o_DONE, o_ERROR;
    logic [7:0] o_BUS_DATA;

    ram_loader #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
        .i_CLOCK(clk), .i_CLEAR_n(rst_n), .i_START(i_START), .i_LENGTH(i_LENGTH),
        .i_ABORT(i_ABORT), .i_WR_VALID(i_WR_VALID), .i_WR_DATA(i_WR_DATA),
        .o_WR_READY(o_WR_READY), .o_BUS_DATA(o_BUS_DATA), .o_BUS_OE(o_BUS_OE),
        .o_MAR_IN(o_MAR_IN), .o_RAM_IN(o_RAM_IN), .o_CPU_CLEAR_n(o_CPU_CLEAR_n),
        .o_BUSY(o_BUSY), .o_DONE(o_DONE), .o_ERROR(o_ERROR)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0, n_err = 0;
    int          cyc = 0;
    int          writes = 0;
    int          dones = 0;
    logic [7:0]  last_mar = '0;
    logic [15:0] exp_q[$];

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bus monitor: every RAM strobe must match the oldest queued {addr, data}.
    always @(negedge clk) begin
        logic [15:0] e;
        if (rst_n) begin
            if (o_MAR_IN) last_mar = o_BUS_DATA;
            if (o_RAM_IN) begin
                writes++;
                if (exp_q.size() == 0) check("ram_unexpected", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    check("ram_addr", {24'h0, last_mar}, {24'h0, e[15:8]});
                    check("ram_data", {24'h0, o_BUS_DATA}, {24'h0, e[7:0]});
                end
            end
            if (o_DONE) dones++;
            if (o_BUS_OE || o_WR_READY || o_MAR_IN || o_RAM_IN) begin
                check("ready_with_oe", o_WR_READY & o_BUS_OE, 0);
                check("oe_vs_strobes", o_BUS_OE, o_MAR_IN ^ o_RAM_IN);
                check("cpu_held", o_CPU_CLEAR_n, 0);
            end
        end
    end

    task automatic start_load(input logic [4:0] len);
        @(posedge clk); #1;
        i_START = 1'b1; i_LENGTH = len;
        @(posedge clk); #1;
        i_START = 1'b0;
    endtask

    // Offer one byte; returns the negedge cycle just before the accepting edge.
    task automatic send(input logic [7:0] d, input logic [3:0] a, input bit toggle, output int acc);
        int t = 0;
        acc = -1;
        i_WR_DATA = d;
        forever begin
            @(negedge clk);
            i_WR_VALID = toggle ? ~i_WR_VALID : 1'b1;
            if (i_WR_VALID && o_WR_READY) break;
            if (++t > 200) begin
                check("send_timeout", 1, 0);
                return;
            end
        end
        acc = cyc;
        exp_q.push_back({4'h0, a, d});
        @(posedge clk); #1;
    endtask

    task automatic wait_done(output int dc);
        int t = 0;
        dc = -1;
        forever begin
            @(negedge clk);
            if (o_DONE) begin
                dc = cyc;
                break;
            end
            if (++t > 300) begin
                check("done_timeout", 0, 1);
                break;
            end
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ready"}, o_WR_READY, 0);
        check({tag, "_bus"}, o_BUS_DATA, 0);
        check({tag, "_strobes"}, {o_BUS_OE, o_MAR_IN, o_RAM_IN}, 0);
        check({tag, "_cpu_clr_n"}, o_CPU_CLEAR_n, 1);
        check({tag, "_busy_done_err"}, {o_BUSY, o_DONE, o_ERROR}, 0);
    endtask

    initial begin
        int acc, acc0, dc, d0;
        logic [7:0] b;

        #12;
        check_reset_vals("reset");
        rst_n = 1'b1;

        // Three bytes, valid always high
        writes = 0;
        start_load(5'd3);
        send(8'h14, 4'h0, 1'b0, acc0);
        send(8'h25, 4'h1, 1'b0, acc);
        send(8'hE0, 4'h2, 1'b0, acc);
        wait_done(dc);
        i_WR_VALID = 1'b0;
        check("t1_done_latency", dc - acc0, 9);
        check("t1_cpu_release", o_CPU_CLEAR_n, 1);
        check("t1_busy_at_done", o_BUSY, 0);
        check("t1_writes", writes, 3);

        // Full depth, valid toggling
        writes = 0;
        start_load(5'd16);
        for (int i = 0; i < 16; i++) send(8'hA0 ^ 8'(i * 7), 4'(i), 1'b1, acc);
        wait_done(dc);
        i_WR_VALID = 1'b0;
        check("t2_writes", writes, 16);
        check("t2_last_addr", last_mar, 8'h0F);
        check("t2_queue_empty", exp_q.size(), 0);

        // Length clamped, with a START pulse mid-load
        writes = 0;
        start_load(5'd20);
        for (int i = 0; i < 16; i++) begin
            if (i == 5) start_load(5'd2);
            send(8'(i * 13 + 3), 4'(i), 1'b0, acc);
        end
        wait_done(dc);
        i_WR_VALID = 1'b0;
        check("t3_writes", writes, 16);
        check("t3_last_addr", last_mar, 8'h0F);
        repeat (4) @(negedge clk);
        check("t3_idle_ready", o_WR_READY, 0);

        // Zero-length load
        writes = 0;
        @(posedge clk); #1;
        i_START = 1'b1; i_LENGTH = 5'd0;
        @(posedge clk); #1;
        i_START = 1'b0;
        @(negedge clk);
        check("t4_done_next", o_DONE, 1);
        check("t4_no_bus", {o_BUS_OE, o_WR_READY}, 0);
        check("t4_cpu", o_CPU_CLEAR_n, 1);
        repeat (3) @(negedge clk);
        check("t4_writes", writes, 0);

        // Abort together with valid on the second byte
        writes = 0;
        d0 = dones;
        start_load(5'd3);
        send(8'h5A, 4'h0, 1'b0, acc);
        i_WR_VALID = 1'b0;
        do @(negedge clk); while (!o_WR_READY && cyc < 20000);
        i_WR_VALID = 1'b1; i_WR_DATA = 8'hC3; i_ABORT = 1'b1;
        @(posedge clk); #1;
        i_WR_VALID = 1'b0; i_ABORT = 1'b0;
        @(negedge clk);
        check("t5_error", o_ERROR, 1);
        check("t5_cpu_held", o_CPU_CLEAR_n, 0);
        check("t5_busy", {o_BUSY, o_WR_READY}, 0);
        repeat (6) @(negedge clk);
        check("t5_writes", writes, 1);
        check("t5_no_done", dones - d0, 0);
        check("t5_cpu_still_held", o_CPU_CLEAR_n, 0);
        start_load(5'd2);
        @(negedge clk);
        check("t5_error_cleared", o_ERROR, 0);
        send(8'h77, 4'h0, 1'b0, acc);
        send(8'h88, 4'h1, 1'b0, acc);
        wait_done(dc);
        i_WR_VALID = 1'b0;
        check("t5_cpu_release", o_CPU_CLEAR_n, 1);
        check("t5_reload_writes", writes, 3);

        // Reset dropped in the middle of a WRITE cycle
        start_load(5'd3);
        b = 8'h9E;
        send(b, 4'h0, 1'b0, acc);
        i_WR_VALID = 1'b0;
        @(posedge clk); #2;
        check("t6_in_write", o_RAM_IN, 1);
        rst_n = 1'b0;
        #1;
        check_reset_vals("t6_async");
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("t6_stays_idle", {o_BUSY, o_WR_READY, o_BUS_OE}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ram_loader.md
Name: ram_loader

Overview:
- Sequences the shared 8-bit bus, MAR and RAM to load a program into RAM before the CPU runs.
- Holds the CPU in clear while loading, through o_CPU_CLEAR_n, which is ANDed externally with the control unit's clear.
- Accepts program bytes over a valid/ready stream and writes them to consecutive addresses starting at 0.
- Sits beside the control unit. Its MAR-in and RAM-in strobes are ORed into the datapath control lines while the CPU is held.

Parameters:
- DATA_WIDTH, 8, bus and RAM word width.
- ADDR_WIDTH, 4, RAM address width; RAM depth is 2^ADDR_WIDTH.

Ports:
- i_CLOCK  in  1  system clock; all state changes on its rising edge.
- i_CLEAR_n  in  1  reset, asynchronous, active-low.
- i_START  in  1  single-cycle load request; sampled only in IDLE.
- i_LENGTH  in  ADDR_WIDTH+1  number of bytes to load; sampled with i_START.
- i_ABORT  in  1  cancels a load in progress.
- i_WR_VALID  in  1  stream byte valid.
- i_WR_DATA  in  DATA_WIDTH  stream byte.
- o_WR_READY  out  1  loader can accept a byte.
- o_BUS_DATA  out  DATA_WIDTH  value driven onto the shared bus.
- o_BUS_OE  out  1  loader owns the bus.
- o_MAR_IN  out  1  MAR load strobe.
- o_RAM_IN  out  1  RAM write strobe.
- o_CPU_CLEAR_n  out  1  0 holds the CPU in clear.
- o_BUSY  out  1  load in progress.
- o_DONE  out  1  one-cycle pulse when a load completes.
- o_ERROR  out  1  sticky flag: last load was aborted.

Behaviour:
- All outputs are registered (Moore, decoded from the registered state and data).
- Reset values:
  - state IDLE, address counter 0, remaining count 0, data register 0.
  - o_WR_READY=0, o_BUS_DATA=0, o_BUS_OE=0, o_MAR_IN=0, o_RAM_IN=0.
  - o_CPU_CLEAR_n=1, o_BUSY=0, o_DONE=0, o_ERROR=0.
- State IDLE:
  - On i_START: latch count = min(i_LENGTH, 2^ADDR_WIDTH), reset address to 0, clear o_ERROR.
  - Count 0 -> go to DONE. Count nonzero -> go to WAIT_BYTE.
  - While i_START is asserted, i_ABORT is ignored.
- State WAIT_BYTE:
  - o_WR_READY=1, o_BUSY=1, o_CPU_CLEAR_n=0.
  - On i_WR_VALID & o_WR_READY: capture i_WR_DATA and go to SET_ADDR.
  - Otherwise stay; no timeout.
- State SET_ADDR (1 cycle): o_BUS_OE=1, o_BUS_DATA = zero-extended address, o_MAR_IN=1. Go to WRITE.
- State WRITE (1 cycle):
  - o_BUS_OE=1, o_BUS_DATA = captured byte, o_RAM_IN=1.
  - Decrement count. Count reaching 0 -> DONE; otherwise address+1 and go to WAIT_BYTE.
- State DONE (1 cycle): o_DONE=1, o_BUSY=0, o_CPU_CLEAR_n=1. Go to IDLE.
- Timing:
  - A byte accepted at edge k gives o_MAR_IN high in cycle k+1 and o_RAM_IN high in cycle k+2.
  - o_WR_READY rises again at cycle k+3. Throughput is at most 1 byte per 3 cycles.
- o_BUS_OE, o_MAR_IN and o_RAM_IN are mutually consistent: at most one strobe per cycle, never asserted in IDLE or DONE.
- o_WR_READY is low in every state except WAIT_BYTE.
- Address wrap: the address increments only while count > 0. With a full-depth load it reaches 2^ADDR_WIDTH-1 and never wraps.
- i_START while busy: ignored, with no effect on count or address.
- i_ABORT in WAIT_BYTE, SET_ADDR or WRITE:
  - Next state is IDLE; o_ERROR=1; o_DONE is not pulsed.
  - o_CPU_CLEAR_n stays 0 until the next successful load or reset, so a partial program never runs.
  - A write in progress during WRITE is still strobed that cycle; abort takes priority over the transition.
- i_ABORT in IDLE or DONE: no effect.
- Simultaneous i_WR_VALID and i_ABORT in WAIT_BYTE: abort wins and the byte is not consumed.
- Reset mid-load: immediately returns to the reset values, including o_CPU_CLEAR_n=1.

Test Plan:
- Reset then START, LENGTH=3, bytes 0x14,0x25,0xE0 with VALID always high:
  - MAR strobes carry 0x00,0x01,0x02; RAM strobes carry 0x14,0x25,0xE0 on alternate cycles.
  - DONE pulses 9 cycles after the first acceptance; CPU_CLEAR_n=0 throughout, then 1.
- LENGTH=16 with VALID toggling every other cycle:
  - 16 writes to addresses 0x0..0xF, READY never high outside WAIT_BYTE, no wrap to 0.
- LENGTH=20: clamped to 16 writes; DONE after the 16th.
- LENGTH=0: DONE on the cycle after START; no bus activity; CPU_CLEAR_n stays 1.
- ABORT asserted together with VALID on the 2nd byte:
  - 1 write only, ERROR=1, no DONE, CPU_CLEAR_n=0.
  - A subsequent START clears ERROR, and a complete load releases the CPU.
- START pulsed during a load: no change in count or address. i_CLEAR_n dropped mid-WRITE: all outputs return to reset values asynchronously.
